// File: rtl/fpu_pkg.sv
// Shared types and floating-point format helpers for the fpu and the units that share it.
package fpu_pkg;

    typedef enum logic [3:0] {
        add_op = 4'd0,
        sub_op = 4'd1,
        mul_op = 4'd2,
        div_op = 4'd3
    } Operation_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        RESPOND
    } Arb_state_t;

    // All-ones pattern of the given width (<= 64): a quiet NaN in every IEEE format.
    function automatic logic [63:0] nan_pattern(input int unsigned width);
        return {64{1'b1}} >> (64 - width);
    endfunction

    function automatic int unsigned exp_size(input int unsigned width);
        case (width)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned mant_size(input int unsigned width);
        return width - exp_size(width) - 1;
    endfunction

    function automatic int unsigned bias_coeff(input int unsigned width);
        return (1 << (exp_size(width) - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_valid
);

    logic [$clog2(N)-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_pos = $clog2(N)'((32'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = w_pos;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sharing of one fpu between CLIENTS requesters, with a result watchdog
// and reserved-opcode rejection that never touches the fpu.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned bitness = 32,
    parameter int unsigned CLIENTS = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CLIENTS-1:0]     req_rdy,
    output logic [CLIENTS-1:0]     req_ack,
    input  logic [CLIENTS*bitness-1:0] req_data_a,
    input  logic [CLIENTS*bitness-1:0] req_data_b,
    input  logic [CLIENTS*4-1:0]   req_operation,
    output logic [CLIENTS-1:0]     resp_rdy,
    input  logic [CLIENTS-1:0]     resp_ack,
    output logic [bitness-1:0]     resp_result,
    output logic                   resp_error,
    output logic                   fpu_input_rdy,
    input  logic                   fpu_input_ack,
    output logic [bitness-1:0]     fpu_data_a,
    output logic [bitness-1:0]     fpu_data_b,
    output logic [3:0]             fpu_operation,
    input  logic                   fpu_output_rdy,
    output logic                   fpu_output_ack,
    input  logic [bitness-1:0]     fpu_result,
    output logic                   busy
);

    localparam int unsigned IW = $clog2(CLIENTS);
    localparam logic [bitness-1:0] NAN = bitness'(nan_pattern(bitness));

    Arb_state_t         r_state;
    logic [IW-1:0]      r_rr_ptr;
    logic [IW-1:0]      r_gnt_idx;
    logic [CLIENTS-1:0] r_gnt_oh;
    logic [CLIENTS-1:0] r_req_ack;
    logic [CLIENTS-1:0] r_resp_rdy;
    logic [bitness-1:0] r_a;
    logic [bitness-1:0] r_b;
    logic [3:0]         r_op;
    logic [bitness-1:0] r_result;
    logic               r_err;
    logic               r_fpu_in_rdy;
    logic               r_fpu_out_ack;
    logic               r_busy;
    logic [15:0]        r_cnt;

    logic [CLIENTS-1:0] w_grant;
    logic [IW-1:0]      w_idx;
    logic               w_valid;
    logic [bitness-1:0] w_a;
    logic [bitness-1:0] w_b;
    logic [3:0]         w_op;
    logic [15:0]        w_cnt_next;

    rr_picker #(.N(CLIENTS)) u_picker (
        .i_req   (req_rdy),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_op = '0;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            if (w_idx == IW'(i)) begin
                w_a  = req_data_a[i*bitness +: bitness];
                w_b  = req_data_b[i*bitness +: bitness];
                w_op = req_operation[i*4 +: 4];
            end
        end
    end

    assign w_cnt_next = r_cnt + 16'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_gnt_idx     <= '0;
            r_gnt_oh      <= '0;
            r_req_ack     <= '0;
            r_resp_rdy    <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_op          <= '0;
            r_result      <= '0;
            r_err         <= 1'b0;
            r_fpu_in_rdy  <= 1'b0;
            r_fpu_out_ack <= 1'b0;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_req_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_a       <= w_a;
                        r_b       <= w_b;
                        r_op      <= w_op;
                        r_gnt_idx <= w_idx;
                        r_gnt_oh  <= w_grant;
                        r_req_ack <= w_grant;
                        r_busy    <= 1'b1;
                        // Reserved opcodes are answered locally; the fpu never sees them.
                        if (w_op > div_op) begin
                            r_result   <= NAN;
                            r_err      <= 1'b1;
                            r_resp_rdy <= w_grant;
                            r_state    <= RESPOND;
                        end else begin
                            r_fpu_in_rdy <= 1'b1;
                            r_state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (fpu_input_ack) begin
                        r_fpu_in_rdy <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cnt_next;
                    if (fpu_output_rdy) begin
                        r_result      <= fpu_result;
                        r_fpu_out_ack <= 1'b1;
                        r_state       <= DRAIN;
                    end else if (w_cnt_next == 16'(TIMEOUT)) begin
                        r_result   <= NAN;
                        r_err      <= 1'b1;
                        r_resp_rdy <= r_gnt_oh;
                        r_state    <= RESPOND;
                    end
                end
                DRAIN: begin
                    if (!fpu_output_rdy) begin
                        r_fpu_out_ack <= 1'b0;
                        r_err         <= 1'b0;
                        r_resp_rdy    <= r_gnt_oh;
                        r_state       <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (resp_ack[r_gnt_idx]) begin
                        r_resp_rdy <= '0;
                        r_busy     <= 1'b0;
                        r_rr_ptr   <= (r_gnt_idx == IW'(CLIENTS - 1)) ? '0 : r_gnt_idx + IW'(1);
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ack        = r_req_ack;
    assign resp_rdy       = r_resp_rdy;
    assign resp_result    = r_result;
    assign resp_error     = r_err;
    assign fpu_input_rdy  = r_fpu_in_rdy;
    assign fpu_data_a     = r_a;
    assign fpu_data_b     = r_b;
    assign fpu_operation  = r_op;
    assign fpu_output_ack = r_fpu_out_ack;
    assign busy           = r_busy;

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter; the bench itself plays the fpu and all clients.
module tb_fpu_arbiter;

    localparam int unsigned BW = 32;
    localparam int unsigned NC = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic [NC-1:0]   req_rdy = '0;
    logic [NC-1:0]   req_ack;
    logic [NC*BW-1:0] req_data_a = '0;
    logic [NC*BW-1:0] req_data_b = '0;
    logic [NC*4-1:0] req_operation = '0;
    logic [NC-1:0]   resp_rdy;
    logic [NC-1:0]   resp_ack = '0;
    logic [BW-1:0]   resp_result;
    logic            resp_error;
    logic            fpu_input_rdy;
    logic            fpu_input_ack = 1'b0;
    logic [BW-1:0]   fpu_data_a;
    logic [BW-1:0]   fpu_data_b;
    logic [3:0]      fpu_operation;
    logic            fpu_output_rdy = 1'b0;
    logic            fpu_output_ack;
    logic [BW-1:0]   fpu_result = '0;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_arbiter #(.bitness(BW), .CLIENTS(NC), .TIMEOUT(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_rdy        (req_rdy),
        .req_ack        (req_ack),
        .req_data_a     (req_data_a),
        .req_data_b     (req_data_b),
        .req_operation  (req_operation),
        .resp_rdy       (resp_rdy),
        .resp_ack       (resp_ack),
        .resp_result    (resp_result),
        .resp_error     (resp_error),
        .fpu_input_rdy  (fpu_input_rdy),
        .fpu_input_ack  (fpu_input_ack),
        .fpu_data_a     (fpu_data_a),
        .fpu_data_b     (fpu_data_b),
        .fpu_operation  (fpu_operation),
        .fpu_output_rdy (fpu_output_rdy),
        .fpu_output_ack (fpu_output_ack),
        .fpu_result     (fpu_result),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] a_val(input int unsigned i);
        return 32'h1000_0000 + i;
    endfunction

    task automatic set_client(input int unsigned i, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] op);
        req_data_a[i*BW +: BW] = a;
        req_data_b[i*BW +: BW] = b;
        req_operation[i*4 +: 4] = op;
    endtask

    // Full transaction: grant, fpu handshake (2-cycle latency) unless reserved, response.
    task automatic run_txn(input string tag, input logic [3:0] reqs, input int unsigned exp_idx,
                           input logic [31:0] fres, input logic reserved);
        logic [3:0] exp_oh;
        exp_oh = 4'b0001 << exp_idx;
        req_rdy = reqs;
        tick();
        for (int n = 0; n < 20 && req_ack == 4'b0; n++) tick();
        check({tag, "_ack"}, 32'(req_ack), 32'(exp_oh));
        req_rdy = reqs & ~exp_oh;
        if (reserved) begin
            check({tag, "_no_fpu"}, 32'(fpu_input_rdy), 32'd0);
        end else begin
            check({tag, "_in_rdy"}, 32'(fpu_input_rdy), 32'd1);
            check({tag, "_data_a"}, fpu_data_a, a_val(exp_idx));
            fpu_input_ack = 1'b1;
            tick();
            fpu_input_ack = 1'b0;
            tick();
            tick();
            fpu_output_rdy = 1'b1;
            fpu_result = fres;
            tick();
            check({tag, "_out_ack"}, 32'(fpu_output_ack), 32'd1);
            fpu_output_rdy = 1'b0;
            tick();
        end
        for (int n = 0; n < 20 && resp_rdy == 4'b0; n++) tick();
        check({tag, "_resp_rdy"}, 32'(resp_rdy), 32'(exp_oh));
        check({tag, "_result"}, resp_result, reserved ? 32'hFFFF_FFFF : fres);
        check({tag, "_error"}, 32'(resp_error), 32'(reserved));
        resp_ack = exp_oh;
        tick();
        resp_ack = '0;
        check({tag, "_resp_clr"}, 32'(resp_rdy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        for (int unsigned i = 0; i < NC; i++) set_client(i, a_val(i), 32'h2000_0000 + i, 4'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {26'd0, fpu_input_rdy, fpu_output_ack, resp_error, 3'd0},
              32'd0);
        check("rst_acks", {24'd0, req_ack, resp_rdy}, 32'd0);
        check("rst_result", resp_result, 32'd0);

        // Single request from client 2: 1.0 + 2.0 = 3.0
        set_client(2, 32'h3F80_0000, 32'h4000_0000, 4'd0);
        req_rdy = 4'b0100;
        tick();
        check("t1_ack", 32'(req_ack), 32'h4);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_rdy", 32'(fpu_input_rdy), 32'd1);
        check("t1_a", fpu_data_a, 32'h3F80_0000);
        check("t1_b", fpu_data_b, 32'h4000_0000);
        check("t1_op", 32'(fpu_operation), 32'd0);
        req_rdy = '0;
        tick();
        check("t1_ack_pulse", 32'(req_ack), 32'd0);
        check("t1_in_rdy_hold", 32'(fpu_input_rdy), 32'd1);
        fpu_input_ack = 1'b1;
        tick();
        fpu_input_ack = 1'b0;
        check("t1_in_rdy_drop", 32'(fpu_input_rdy), 32'd0);
        tick();
        fpu_output_rdy = 1'b1;
        fpu_result = 32'h4040_0000;
        tick();
        check("t1_out_ack", 32'(fpu_output_ack), 32'd1);
        check("t1_no_resp_yet", 32'(resp_rdy), 32'd0);
        fpu_output_rdy = 1'b0;
        tick();
        check("t1_out_ack_drop", 32'(fpu_output_ack), 32'd0);
        check("t1_resp_rdy", 32'(resp_rdy), 32'h4);
        check("t1_result", resp_result, 32'h4040_0000);
        check("t1_error", 32'(resp_error), 32'd0);
        resp_ack = 4'b0001;
        tick();
        check("t1_foreign_ack", 32'(resp_rdy), 32'h4);
        resp_ack = 4'b0100;
        tick();
        resp_ack = '0;
        check("t1_resp_clr", 32'(resp_rdy), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        set_client(2, a_val(2), 32'h2000_0002, 4'd0);

        // Pointer now 3: of {0,3}, client 3 wins
        run_txn("ptr3", 4'b1001, 3, 32'h1111_0000, 1'b0);
        req_rdy = '0;

        // Contention from pointer 0
        run_txn("c0", 4'b1111, 0, 32'hC000_0000, 1'b0);
        run_txn("c1", 4'b1110, 1, 32'hC000_0001, 1'b0);
        run_txn("c2", 4'b1100, 2, 32'hC000_0002, 1'b0);
        run_txn("c3", 4'b1000, 3, 32'hC000_0003, 1'b0);
        req_rdy = '0;

        // Reserved opcode from client 1
        set_client(1, a_val(1), 32'h2000_0001, 4'b0101);
        run_txn("rsv", 4'b0010, 1, 32'h0, 1'b1);
        req_rdy = '0;
        set_client(1, a_val(1), 32'h2000_0001, 4'd0);

        // Timeout: fpu accepts but never answers
        req_rdy = 4'b0001;
        tick();
        check("to_ack", 32'(req_ack), 32'h1);
        req_rdy = '0;
        fpu_input_ack = 1'b1;
        tick();
        fpu_input_ack = 1'b0;
        repeat (7) tick();
        check("to_early", 32'(resp_rdy), 32'd0);
        tick();
        check("to_resp_rdy", 32'(resp_rdy), 32'h1);
        check("to_result", resp_result, 32'hFFFF_FFFF);
        check("to_error", 32'(resp_error), 32'd1);
        resp_ack = 4'b0001;
        tick();
        resp_ack = '0;
        run_txn("after_to", 4'b1000, 3, 32'h1234_5678, 1'b0);
        req_rdy = '0;

        // Result arrives on the very cycle the watchdog would fire
        req_rdy = 4'b0100;
        tick();
        check("tie_ack", 32'(req_ack), 32'h4);
        req_rdy = '0;
        fpu_input_ack = 1'b1;
        tick();
        fpu_input_ack = 1'b0;
        repeat (7) tick();
        fpu_output_rdy = 1'b1;
        fpu_result = 32'h40A0_0000;
        tick();
        check("tie_out_ack", 32'(fpu_output_ack), 32'd1);
        check("tie_no_to", 32'(resp_rdy), 32'd0);
        fpu_output_rdy = 1'b0;
        tick();
        check("tie_resp_rdy", 32'(resp_rdy), 32'h4);
        check("tie_result", resp_result, 32'h40A0_0000);
        check("tie_error", 32'(resp_error), 32'd0);
        resp_ack = 4'b0100;
        tick();
        resp_ack = '0;

        // Async reset while waiting on the fpu (pointer is 3 beforehand)
        req_rdy = 4'b0010;
        tick();
        req_rdy = '0;
        fpu_input_ack = 1'b1;
        tick();
        fpu_input_ack = 1'b0;
        tick();
        check("ar_busy_pre", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_outs", {26'd0, fpu_input_rdy, fpu_output_ack, resp_error, 3'd0}, 32'd0);
        check("ar_acks", {24'd0, req_ack, resp_rdy}, 32'd0);
        check("ar_result", resp_result, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("ar_idle", 32'(busy), 32'd0);
        run_txn("ar_ptr0", 4'b1010, 1, 32'h5555_AAAA, 1'b0);
        req_rdy = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_arbiter.md
Name: fpu_arbiter

Overview:
- Shares one fpu instance between CLIENTS independent requesters using round-robin arbitration.
- Captures one client's operands and operation, then runs the full fpu input/output handshake.
- Returns the result, plus an error flag, to the same client.
- Adds a result watchdog and rejects reserved opcodes without using the fpu.

Parameters:
bitness, 32, operand/result width; passed through to the fpu
CLIENTS, 4, number of requesters (2..8)
TIMEOUT, 255, max cycles waiting for fpu_output_rdy before an error response (1..65535)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_rdy  in  CLIENTS  per-client request valid; held until matching req_ack
req_ack  out  CLIENTS  one-cycle pulse: request captured
req_data_a  in  CLIENTS*bitness  operand A; slice i belongs to client i
req_data_b  in  CLIENTS*bitness  operand B; slice i belongs to client i
req_operation  in  CLIENTS*4  Operation_t per client
resp_rdy  out  CLIENTS  result valid for client i; held until resp_ack[i]
resp_ack  in  CLIENTS  client accepts result
resp_result  out  bitness  shared result bus; valid for the client whose resp_rdy is high
resp_error  out  1  valid with resp_rdy: reserved opcode or timeout
fpu_input_rdy  out  1  to fpu input_rdy
fpu_input_ack  in  1  from fpu input_ack
fpu_data_a  out  bitness  to fpu data_a
fpu_data_b  out  bitness  to fpu data_b
fpu_operation  out  4  to fpu operation
fpu_output_rdy  in  1  from fpu output_rdy
fpu_output_ack  out  1  to fpu output_ack
fpu_result  in  bitness  from fpu result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset==0, async): state=IDLE; rr_ptr=0; all outputs 0 (req_ack, resp_rdy, resp_error, fpu_input_rdy, fpu_output_ack, busy); data registers 0; timeout counter 0. Reset mid-transaction abandons it. No fpu_output_ack is issued, and the fpu is reset from the same source.
- Arbitration in IDLE: scan req_rdy starting at rr_ptr, wrapping modulo CLIENTS. The first set bit wins (grant g). Simultaneous requests are resolved only by the scan order.
- IDLE -> ISSUE on a grant, in one cycle:
  - register a, b and operation from slice g;
  - pulse req_ack[g] for exactly one cycle;
  - store g.
- Reserved opcode (operation > div_op): go IDLE -> RESPOND directly with resp_result = all-ones (NaN pattern) and resp_error=1. The fpu is untouched.
- ISSUE:
  - fpu_input_rdy=1, with fpu_data_a/b/operation driven from the registers and stable.
  - On the first cycle with fpu_input_ack=1: drop fpu_input_rdy next cycle, clear the timeout counter, go to WAIT.
  - No timeout applies in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - When fpu_output_rdy=1: capture fpu_result, assert fpu_output_ack, go to DRAIN.
  - If the counter reaches TIMEOUT first: go to RESPOND with resp_result=all-ones and resp_error=1.
  - fpu_output_rdy and the timeout in the same cycle: the result wins.
- DRAIN: hold fpu_output_ack=1 until fpu_output_rdy==0, then deassert it and go to RESPOND with resp_error=0.
- RESPOND: resp_rdy[g]=1 and resp_result stable. On resp_ack[g]=1: resp_rdy[g]=0, rr_ptr=(g+1) mod CLIENTS, go to IDLE.
- resp_ack on other bits is ignored.
- Latency: request accepted to resp_rdy is at least 4 cycles plus the fpu latency. Back-to-back grants are possible on the cycle after resp_ack.
- Only one transaction is ever outstanding. Requests stay pending, unacked, while busy.
- req_rdy dropped before req_ack is a protocol violation; behaviour is undefined except that the arbiter never deadlocks.
- Exactly one resp_rdy bit is ever high, and req_ack is one-hot or zero.

Decomposition:
- Shared package fpu_pkg:
  - Operation_t (add_op=0, sub_op=1, mul_op=2, div_op=3);
  - Arb_state_t (IDLE, ISSUE, WAIT, DRAIN, RESPOND);
  - NaN constant function;
  - EXP_SIZE/MANT_SIZE/BIAS_COEFF helpers, replacing the macros.
- Sub-module rr_picker: combinational, with req vector and pointer in, one-hot grant plus index out. Reusable by future shared units.

Test Plan:
- Single request: client 2 sends a=0x3F800000, b=0x40000000, add_op. Required: req_ack[2] pulses once; fpu sees the operands; resp_rdy[2] rises with resp_result = the fpu result and resp_error=0; rr_ptr becomes 3.
- Contention: req_rdy=4'b1111 held for 4 transactions from rr_ptr=0. Required grant order 0,1,2,3; no client acked twice; each resp_rdy one-hot.
- Reserved op: client 1, operation=4'b0101. Required: no fpu_input_rdy; resp_rdy[1] with resp_result=0xFFFFFFFF and resp_error=1.
- Timeout: TIMEOUT=8, fpu model never raises output_rdy. Required: resp_error=1 and result 0xFFFFFFFF exactly 8 cycles after WAIT entry; then the next request is served.
- Result/timeout tie: output_rdy first rises in the same cycle the counter hits TIMEOUT. Required: real result returned, resp_error=0.
- Async reset asserted in WAIT, between clock edges. Required: all outputs 0 immediately; after release, state IDLE and rr_ptr=0.
